// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling behind a two-flop synchronizer.
// Delivers each good byte with a one-cycle strobe and flags bad stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [8:0] BIT_LAST = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_BIT = 9'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t     state, state_next;
  logic       rx_meta, rx_s;
  logic [8:0] cnt, cnt_next;
  logic [2:0] idx, idx_next;
  logic [7:0] shift, shift_next;
  logic [7:0] byte_q, byte_next;
  logic       dv_q, dv_next;
  logic       err_q, err_next;
  logic       active_q, active_next;

  // Synchronizer flops idle high so reset release never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      byte_q   <= byte_next;
      dv_q     <= dv_next;
      err_q    <= err_next;
      active_q <= active_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    shift_next  = shift;
    byte_next   = byte_q;
    dv_next     = 1'b0;
    err_next    = 1'b0;
    active_next = active_q;

    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rx_s) begin
          state_next  = START;
          active_next = 1'b1;
        end
      end

      // A start bit that is no longer low at its centre is treated as noise.
      START: begin
        if (cnt == HALF_BIT) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
          end else begin
            state_next  = IDLE;
            active_next = 1'b0;
          end
        end else begin
          cnt_next = cnt + 9'd1;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_next   = '0;
            state_next = STOP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + 9'd1;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next    = '0;
          active_next = 1'b0;
          if (rx_s) begin
            byte_next  = shift;
            dv_next    = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 9'd1;
        end
      end

      // Hold off after a framing error so a break yields a single error pulse.
      WAIT_HIGH: begin
        cnt_next    = '0;
        idx_next    = '0;
        active_next = 1'b0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        state_next  = IDLE;
        cnt_next    = '0;
        idx_next    = '0;
        active_next = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial driver pushes expected bytes to a
// scoreboard and a monitor pops and compares them on every o_Rx_DV strobe.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock;
  logic       resetN;
  logic       rxSerial;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       rxActive;
  logic       rxFrameErr;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frameStart = 0;
  int         lastDvDelta = 0;
  int         dvCount = 0;
  int         ferrCount = 0;
  int         activeCycles = 0;
  int         base;
  logic       dvPrev = 1'b0;
  logic [7:0] expQ[$];
  int         dvTimes[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clock),
    .i_Reset_n      (resetN),
    .i_Rx_Serial    (rxSerial),
    .o_Rx_DV        (rxDv),
    .o_Rx_Byte      (rxByte),
    .o_Rx_Active    (rxActive),
    .o_Rx_Frame_Err (rxFrameErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  // Drives one frame starting at the current negedge and returns on a negedge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopLevel,
                               input int stopBitTimes, input int idleBitTimes,
                               input bit expectGood);
    if (expectGood) expQ.push_back(data);
    frameStart = cyc + 1;
    rxSerial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxSerial = data[i];
      repeat (CPB) @(negedge clock);
    end
    rxSerial = stopLevel;
    repeat (CPB * stopBitTimes) @(negedge clock);
    rxSerial = 1'b1;
    repeat (CPB * idleBitTimes) @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (rxDv && rxFrameErr) checkOutput("dv_err_overlap", {rxDv, rxFrameErr}, 2'b00);
    if (rxDv) begin
      checkOutput("dv_width", dvPrev, 1'b0);
      dvTimes.push_back(cyc);
      lastDvDelta = cyc - frameStart;
      dvCount++;
      if (expQ.size() == 0) checkOutput("dv_unexpected", expQ.size(), 1);
      else checkOutput("dv_byte", rxByte, expQ.pop_front());
    end
    if (rxFrameErr) ferrCount++;
    dvPrev = rxDv;
  end

  initial begin
    resetN   = 1'b0;
    rxSerial = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_dv", rxDv, 1'b0);
    checkOutput("rst_byte", rxByte, 8'h00);
    checkOutput("rst_active", rxActive, 1'b0);
    checkOutput("rst_ferr", rxFrameErr, 1'b0);
    resetN = 1'b1;
    repeat (4) @(negedge clock);

    // Frame 0xA5 with exact timing of active rise and DV strobe
    fork
      applyStimulus(8'hA5, 1'b1, 1, 2, 1'b1);
      begin
        repeat (2) @(posedge clock);
        #1 checkOutput("active_edge1", rxActive, 1'b0);
        @(posedge clock);
        #1 checkOutput("active_edge2", rxActive, 1'b1);
      end
    join
    checkOutput("a5_dv_time", lastDvDelta, 154);
    checkOutput("a5_byte_hold", rxByte, 8'hA5);
    checkOutput("a5_ferr", ferrCount, 0);

    // Four-cycle low glitch on an idle line
    base = dvCount;
    fork
      begin
        rxSerial = 1'b0;
        repeat (4) @(negedge clock);
        rxSerial = 1'b1;
      end
      begin
        activeCycles = 0;
        repeat (20) begin
          @(posedge clock);
          #1 if (rxActive) activeCycles++;
        end
      end
    join
    @(negedge clock);
    checkOutput("glitch_active_len", activeCycles, 8);
    checkOutput("glitch_dv", dvCount - base, 0);
    checkOutput("glitch_ferr", ferrCount, 0);
    checkOutput("glitch_byte", rxByte, 8'hA5);

    // Good byte, then a break-like stop bit, then recovery
    applyStimulus(8'h12, 1'b1, 1, 1, 1'b1);
    base = dvCount;
    applyStimulus(8'h3C, 1'b0, 3, 2, 1'b0);
    checkOutput("ferr_pulses", ferrCount, 1);
    checkOutput("ferr_no_dv", dvCount - base, 0);
    checkOutput("ferr_byte_hold", rxByte, 8'h12);
    checkOutput("ferr_active", rxActive, 1'b0);
    applyStimulus(8'h81, 1'b1, 1, 2, 1'b1);
    checkOutput("recover_byte", rxByte, 8'h81);

    // Back-to-back frames with single stop bits
    dvTimes.delete();
    applyStimulus(8'h00, 1'b1, 1, 0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1, 0, 1'b1);
    applyStimulus(8'h55, 1'b1, 1, 2, 1'b1);
    checkOutput("b2b_count", dvTimes.size(), 3);
    if (dvTimes.size() == 3) begin
      checkOutput("b2b_gap1", dvTimes[1] - dvTimes[0], 160);
      checkOutput("b2b_gap2", dvTimes[2] - dvTimes[1], 160);
    end

    // Reset during data bit 4 of 0xF0
    base = dvCount;
    fork
      applyStimulus(8'hF0, 1'b1, 1, 1, 1'b0);
      begin
        repeat (88) @(posedge clock);
        #2 resetN = 1'b0;
        #1;
        checkOutput("midrst_dv", rxDv, 1'b0);
        checkOutput("midrst_byte", rxByte, 8'h00);
        checkOutput("midrst_active", rxActive, 1'b0);
        checkOutput("midrst_ferr", rxFrameErr, 1'b0);
      end
    join
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("midrst_no_dv", dvCount - base, 0);
    applyStimulus(8'h7E, 1'b1, 1, 2, 1'b1);
    checkOutput("post_rst_byte", rxByte, 8'h7E);

    // Every byte value back to back
    base = dvCount;
    for (int v = 0; v < 256; v++) applyStimulus(8'(v), 1'b1, 1, 0, 1'b1);
    repeat (CPB) @(negedge clock);
    checkOutput("sweep_count", dvCount - base, 256);
    checkOutput("sweep_ferr", ferrCount, 1);
    checkOutput("sb_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
